// File: rtl/quantize_stream.sv
// Streaming int8 quantizer: out = sat(round(|x| * S / 2^FRAC_BITS)) with sign.
// Define QUANT_ROUND_EN for round-half-up on magnitude; otherwise truncation.
module quantize_stream #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 24,
    parameter int QMAX      = 127
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scale_ready,
    input  logic [31:0]       reciprocal_scale,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

`ifdef QUANT_ROUND_EN
    localparam logic [63:0] RND = 64'(1) << (FRAC_BITS - 1);
`else
    localparam logic [63:0] RND = '0;
`endif

    state_t state, state_next;

    logic [31:0]     scale_reg;
    logic            s1_valid;
    logic            s1_neg;
    logic            s1_last;
    logic [63:0]     s1_prod;

    logic            advance;
    logic            in_fire;
    logic            out_fire;
    logic            in_neg;
    logic [DATA_W:0] in_abs;
    logic [63:0]     rounded;
    logic [63:0]     mag;
    logic [7:0]      q_mag;
    logic [7:0]      q_val;

    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == RUN) && advance;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != IDLE);

    // 33-bit magnitude so that the most negative input is representable
    assign in_neg = in_data[DATA_W-1];
    assign in_abs = in_neg ? ({1'b0, ~in_data} + (DATA_W+1)'(1))
                           : {1'b0, in_data};

    assign rounded = s1_prod + RND;
    assign mag     = rounded >> FRAC_BITS;
    assign q_mag   = (mag > 64'(QMAX)) ? 8'(QMAX) : mag[7:0];
    assign q_val   = s1_neg ? (8'd0 - q_mag) : q_mag;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (scale_ready) state_next = RUN;
            RUN:     if (in_fire && in_last) state_next = DRAIN;
            DRAIN:   if (out_fire && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scale_reg <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DRAIN) && out_fire && out_last;
            if (state == IDLE && scale_ready)
                scale_reg <= reciprocal_scale;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_neg    <= 1'b0;
            s1_last   <= 1'b0;
            s1_prod   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_fire;
            s1_neg    <= in_neg;
            s1_last   <= in_last;
            s1_prod   <= 64'(in_abs) * 64'(scale_reg);
            out_valid <= s1_valid;
            out_data  <= q_val;
            out_last  <= s1_last;
        end
    end

endmodule

// File: tb/tb_quantize_stream.sv
// Directed bench for quantize_stream: table of tensors and vectors,
// plus reset-mid-stream and scale-glitch sequences.
module tb_quantize_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        scale_ready;
    logic [31:0] reciprocal_scale;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    quantize_stream dut (
        .clk(clk),
        .reset(reset),
        .scale_ready(scale_ready),
        .reciprocal_scale(reciprocal_scale),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] S = 32'd21307064;

    typedef struct {
        logic [31:0] x;
        logic        last;
        int          er;
        int          et;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        int          first;
        int          n;
        int          hold;
        bit          glitch;
    } ten_t;

    vec_t v[19];
    ten_t t[6];

    int cyc = 0;
    int done_cnt = 0;
    int checks = 0;
    int fails = 0;
    int acc_cyc;
    int first_out;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done) done_cnt++;

    function automatic int expv(int i);
`ifdef QUANT_ROUND_EN
        return v[i].er;
`else
        return v[i].et;
`endif
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(int i, int x, bit last, int er, int et);
        v[i].x    = x;
        v[i].last = last;
        v[i].er   = er;
        v[i].et   = et;
    endtask

    task automatic start(logic [31:0] s);
        reciprocal_scale = s;
        scale_ready = 1'b1;
        @(negedge clk);
        check("busy_idle", int'(busy), 0);
        check("in_ready_idle", int'(in_ready), 0);
        tick();
        scale_ready = 1'b0;
        reciprocal_scale = 32'hdead_beef;
        @(negedge clk);
        check("busy_run", int'(busy), 1);
        check("in_ready_run", int'(in_ready), 1);
        tick();
    endtask

    task automatic send(int first, int n);
        for (int i = 0; i < n; i++) begin
            bit ok;
            ok = 1'b0;
            in_valid = 1'b1;
            in_data  = v[first+i].x;
            in_last  = v[first+i].last;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    if (i == 0) acc_cyc = cyc;
                end
                tick();
            end
            if (!ok) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: element %0d not accepted", first + i);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(int first, int n, int hold);
        int got;
        got = 0;
        first_out = -1;
        out_ready = (hold == 0);
        for (int c = 0; c < 400 && got < n; c++) begin
            if (c == hold) out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && first_out < 0) first_out = cyc;
            if (c < hold && out_valid)
                check("hold_data", int'($signed(out_data)), expv(first));
            if (c == hold - 1)
                check("in_ready_stall", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                check("out_data", int'($signed(out_data)), expv(first + got));
                check("out_last", int'(out_last), int'(v[first+got].last));
                got++;
            end
            tick();
        end
        out_ready = 1'b1;
        if (got < n) begin
            checks++;
            fails++;
            $display("FAIL recv_timeout: got %0d outputs, required %0d", got, n);
        end
    endtask

    task automatic glitch();
        tick();
        reciprocal_scale = 32'd1;
        scale_ready = 1'b1;
        tick();
        scale_ready = 1'b0;
    endtask

    task automatic run_tensor(int ti);
        int d0;
        d0 = done_cnt;
        start(t[ti].s);
        fork
            send(t[ti].first, t[ti].n);
            recv(t[ti].first, t[ti].n, t[ti].hold);
            begin
                if (t[ti].glitch) glitch();
            end
        join
        if (t[ti].hold == 0) check("latency", first_out - acc_cyc, 2);
        @(negedge clk);
        @(negedge clk);
        check("done_pulse", done_cnt - d0, 1);
        check("busy_after", int'(busy), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        setv(0, 100, 0, 127, 126);
        setv(1, -100, 0, -127, -126);
        setv(2, 25, 0, 32, 31);
        setv(3, 0, 0, 0, 0);
        setv(4, -1, 1, -1, -1);
        setv(5, 1000, 0, 127, 127);
        setv(6, 32'h8000_0000, 0, -127, -127);
        setv(7, 32'h7fff_ffff, 1, 127, 127);
        setv(8, 50, 0, 63, 63);
        setv(9, -50, 0, -63, -63);
        setv(10, 7, 0, 9, 8);
        setv(11, 3, 1, 4, 3);
        setv(12, 5, 0, 0, 0);
        setv(13, -7, 0, 0, 0);
        setv(14, 32'h4000_0000, 1, 0, 0);
        setv(15, 25, 0, 32, 31);
        setv(16, 10, 0, 13, 12);
        setv(17, -25, 1, -32, -31);
        setv(18, -100, 1, -127, -126);

        t[0] = '{S, 0, 5, 0, 1'b0};
        t[1] = '{S, 5, 3, 0, 1'b0};
        t[2] = '{S, 8, 4, 5, 1'b0};
        t[3] = '{32'd0, 12, 3, 0, 1'b0};
        t[4] = '{S, 15, 3, 0, 1'b1};
        t[5] = '{S, 18, 1, 0, 1'b0};

        reset = 1'b1;
        scale_ready = 1'b0;
        reciprocal_scale = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_tensor(i);

        start(S);
        in_valid = 1'b1;
        in_data = 32'd100;
        in_last = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_out_valid", int'(out_valid), 0);
        tick();

        run_tensor(5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
